serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder producing the 12-bit binary value consumed by the 4-digit decimal 7-segment display stage.
- Captures two WIDTH-bit operands on a start request and adds them LSB-first, one bit per clock, through a single carry flip-flop.
- Presents a registered, zero-extended sum that stays stable between operations, so the display never shows partial results.

Parameters:
- WIDTH, 10, operand width in bits; 1023+1023 = 2046 stays inside the display's 0..2999 range.
- OUT_W, 12, sum output width; must satisfy OUT_W >= WIDTH+1 (elaboration-time check, error otherwise).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request level (debounced button); the block acts on its rising edge.
- a  input  WIDTH  operand A, sampled only on an accepted start.
- b  input  WIDTH  operand B, sampled only on an accepted start.
- sum  output  OUT_W  registered result {zeros, carry, WIDTH sum bits}; drives the display input.
- busy  output  1  high while an addition is in progress.
- done  output  1  single-cycle pulse when sum updates.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, sum=0, busy=0, done=0. Internal registers are cleared: a_sr, b_sr, s_sr, carry, cnt, and start_q (the start edge detector).
- Start detect:
  - start_q <= start every cycle.
  - start_rise = start & ~start_q.
  - Holding start high therefore triggers exactly one operation.
- State machine (IDLE, SHIFT, FINISH):
  - IDLE, start_rise=1:
    - a_sr<=a, b_sr<=b, carry<=0, cnt<=0, s_sr<=0.
    - busy<=1, state<=SHIFT.
  - SHIFT, every edge:
    - s = a_sr[0]^b_sr[0]^carry.
    - carry <= majority(a_sr[0], b_sr[0], carry).
    - s_sr <= {s, s_sr[WIDTH-1:1]}.
    - a_sr and b_sr logically shift right by 1.
    - cnt <= cnt+1.
    - When cnt==WIDTH-1: state<=FINISH.
  - FINISH, one edge:
    - sum <= zero-extend {carry, s_sr}.
    - done<=1, busy<=0, state<=IDLE.
  - done deasserts on the following edge.
- Latency:
  - start_rise sampled at edge E0; SHIFT occupies edges E1..E_WIDTH.
  - sum and done update at edge E_(WIDTH+1).
  - With default WIDTH, done is high for the cycle after E11.
- Boundaries:
  - start_rise while busy (SHIFT or FINISH): ignored, and operands are not resampled. A start held high through FINISH does not retrigger, because no new rising edge occurs.
  - start rising in the same cycle that done is high (state IDLE): accepted normally, i.e. back-to-back operation.
  - a or b changing during SHIFT: no effect.
  - sum holds its previous value for the whole operation and changes only at FINISH.
  - Maximum result (2^WIDTH-1)*2 fits without truncation. Bits above WIDTH in sum are always 0.
  - rst_n asserted mid-operation: immediate return to reset values, operation aborted, sum=0.
- cnt width is clog2(WIDTH); it never wraps, because cnt leaves SHIFT at WIDTH-1.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_FINISH=2'd2;
  - default WIDTH/OUT_W constants reused by the display-side top level.
- One natural sub-module: full_adder_bit, a combinational cell with inputs a, b, cin and outputs s, cout, instantiated once in the datapath.
- The FSM, counter and shift registers stay in serial_adder_ctrl.

Test Plan:
- Reset, then a=5, b=3, pulse start at E0:
  - busy high for E1..E10;
  - done pulses after E11;
  - sum=12'd8;
  - sum=0 before E11.
- a=1023, b=1023:
  - sum=12'd2046 (12'h7FE), carry bit sum[10]=1;
  - sum[11]=0.
- Hold start high for 30 cycles with a=0, b=0:
  - exactly one done pulse, sum=0;
  - busy low after completion.
- Start at E0 with a=100, b=200; toggle start again at E4 with a=7, b=7 presented:
  - second request ignored;
  - sum=12'd300 after E11;
  - only one done pulse.
- Complete 600+400 (sum=1000), then start 10+20 with rst_n pulsed low at E5 (asynchronous, mid-clock):
  - sum, busy and done go 0 immediately;
  - after release, a fresh start on 10+20 gives sum=30.
- Back-to-back: start rises on the done cycle of 512+511 (result 1023); next operands 1+1:
  - second done 11 edges later;
  - sum=2.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default widths for the serial adder and display-side top level
package serial_adder_pkg;
  localparam int WIDTH_DEF = 10;
  localparam int OUT_W_DEF = 12;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_FINISH = 2'd2} state_t;
endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: one-bit full adder cell; ports a, b, cin in; s (sum), cout (carry) out
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder; ports clk, rst_n (async low), start (rising edge), a/b operands in; sum (held, zero-extended), busy, done (1-cycle) out
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [OUT_W-1:0] sum,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH > 1 ? WIDTH : 2);
  if (OUT_W < WIDTH + 1) begin : g_chk
    $error("OUT_W must be at least WIDTH+1");
  end
  state_t state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic [CW-1:0] cnt;
  logic carry, start_q, start_rise, s, cout;
  assign start_rise = start & ~start_q;
  full_adder_bit u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(carry), .s(s), .cout(cout));
  always_comb begin
    state_n = ST_IDLE;
    case (state)
      ST_IDLE:  state_n = start_rise ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: state_n = (cnt == CW'(WIDTH - 1)) ? ST_FINISH : ST_SHIFT;
      default:  state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      s_sr <= '0;
      carry <= 1'b0;
      cnt <= '0;
      start_q <= 1'b0;
      sum <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      start_q <= start;
      done <= 1'b0;
      if (state == ST_IDLE && start_rise) begin
        a_sr <= a;
        b_sr <= b;
        s_sr <= '0;
        carry <= 1'b0;
        cnt <= '0;
        busy <= 1'b1;
      end else if (state == ST_SHIFT) begin
        s_sr <= {s, s_sr[WIDTH-1:1]};
        carry <= cout;
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        cnt <= cnt + 1'b1;
      end else if (state == ST_FINISH) begin
        sum <= OUT_W'({carry, s_sr});
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n, start;
  logic [9:0] a, b;
  logic [11:0] sum;
  logic busy, done;
  int total = 0, bad = 0, dones = 0;
  serial_adder_ctrl dut (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sum(sum), .busy(busy), .done(done));
  always #5 clk = ~clk;
  always @(negedge clk) if (done) dones++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [9:0] x, input logic [9:0] y);
    a = x;
    b = y;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(11);
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    step(2);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    step(1);
    a = 10'd5;
    b = 10'd3;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("e0_busy", 32'(busy), 1);
    chk("e0_sum", 32'(sum), 0);
    step(10);
    chk("e10_busy", 32'(busy), 1);
    chk("e10_sum", 32'(sum), 0);
    chk("e10_done", 32'(done), 0);
    step(1);
    chk("e11_done", 32'(done), 1);
    chk("e11_sum", 32'(sum), 8);
    chk("e11_busy", 32'(busy), 0);
    step(1);
    chk("e12_done", 32'(done), 0);
    chk("e12_sum", 32'(sum), 8);
    op(10'd1023, 10'd1023);
    chk("max_sum", 32'(sum), 2046);
    chk("max_b10", 32'(sum[10]), 1);
    chk("max_b11", 32'(sum[11]), 0);
    step(1);
    dones = 0;
    a = '0;
    b = '0;
    start = 1'b1;
    step(30);
    start = 1'b0;
    step(2);
    chk("hold_dones", 32'(dones), 1);
    chk("hold_sum", 32'(sum), 0);
    chk("hold_busy", 32'(busy), 0);
    dones = 0;
    a = 10'd100;
    b = 10'd200;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    a = 10'd7;
    b = 10'd7;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(6);
    chk("ign_sum_pre", 32'(sum), 0);
    step(1);
    chk("ign_done", 32'(done), 1);
    chk("ign_sum", 32'(sum), 300);
    step(3);
    chk("ign_dones", 32'(dones), 1);
    op(10'd600, 10'd400);
    chk("pre_rst_sum", 32'(sum), 1000);
    step(1);
    a = 10'd10;
    b = 10'd20;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sum", 32'(sum), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    step(1);
    rst_n = 1'b1;
    step(1);
    op(10'd10, 10'd20);
    chk("post_rst_sum", 32'(sum), 30);
    step(1);
    a = 10'd512;
    b = 10'd511;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(11);
    chk("b2b_done1", 32'(done), 1);
    chk("b2b_sum1", 32'(sum), 1023);
    a = 10'd1;
    b = 10'd1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 1);
    step(10);
    chk("b2b_done_early", 32'(done), 0);
    chk("b2b_sum_hold", 32'(sum), 1023);
    step(1);
    chk("b2b_done2", 32'(done), 1);
    chk("b2b_sum2", 32'(sum), 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
